// File: rtl/scan_mux_nto1.sv
// ---------------------------------------------------------------------------
// scan_mux_nto1
//   Registered N:1 word multiplexer with two ways of choosing the channel:
//   manual select (i_mode=0) shows the channel named by i_sel; auto-scan
//   (i_mode=1) steps round-robin through the channels enabled in i_en_mask
//   and shows each one for DWELL cycles. Feeds the display/probe datapath.
//
// Ports
//   i_clk       clock, all state on the rising edge
//   i_rst       asynchronous active-high reset
//   i_data_in   CHANNELS words, channel k = i_data_in[k*WIDTH +: WIDTH]
//   i_mode      0 = manual select, 1 = auto-scan
//   i_sel       manual channel select, also the scan start point
//   i_en_mask   per-channel scan enable (ignored in manual mode)
//   i_hold      scan mode: freeze channel and dwell count
//   o_data_out  registered selected word
//   o_ch_out    channel index that o_data_out came from
//   o_valid     o_data_out/o_ch_out meaningful this cycle
//   o_wrap      1-cycle pulse when the scan wraps back to a lower channel
// ---------------------------------------------------------------------------
module scan_mux_nto1 #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS*WIDTH-1:0] i_data_in,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [CHANNELS-1:0]       i_en_mask,
  input  logic                      i_hold,
  output logic [WIDTH-1:0]          o_data_out,
  output logic [SEL_W-1:0]          o_ch_out,
  output logic                      o_valid,
  output logic                      o_wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CUR_MAX    = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CH_LIM     = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_cur, w_cur_nxt;
  logic [DW_W-1:0]   r_dwell, w_dwell_nxt;
  logic [WIDTH-1:0]  r_data, w_data_nxt;
  logic [SEL_W-1:0]  r_ch, w_ch_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_wrap, w_wrap_nxt;

  logic              w_any_en;
  logic              w_sel_ok;
  logic [SEL_W-1:0]  w_sel_norm;
  logic [SEL_W-1:0]  w_entry_ch;
  logic [SEL_W-1:0]  w_after_cur;
  logic [SEL_W-1:0]  w_next_ch;
  logic [SEL_W-1:0]  w_recover_ch;
  logic [WIDTH-1:0]  w_man_data;

  // Word of channel idx; indices with no matching channel read as zero.
  function automatic logic [WIDTH-1:0] f_word(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        w = d[k*WIDTH +: WIDTH];
      end
    end
    return w;
  endfunction

  // First enabled channel at or above start, wrapping round; start itself if
  // nothing is enabled. start must already be a legal channel index.
  function automatic logic [SEL_W-1:0] f_first_from(
    input logic [CHANNELS-1:0] mask,
    input logic [SEL_W-1:0]    start
  );
    logic [SEL_W-1:0] res;
    logic             found;
    int               idx;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(start) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!found && mask[idx]) begin
        res   = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_any_en     = |i_en_mask;
  assign w_sel_ok     = ({1'b0, i_sel} < CH_LIM);
  assign w_sel_norm   = w_sel_ok ? i_sel : '0;
  assign w_entry_ch   = f_first_from(i_en_mask, w_sel_norm);
  // Strictly-above search: start one past cur so cur is only found again
  // when it is the sole enabled channel (which is then a wrap).
  assign w_after_cur  = (r_cur == CUR_MAX) ? '0 : (r_cur + SEL_W'(1));
  assign w_next_ch    = f_first_from(i_en_mask, w_after_cur);
  assign w_recover_ch = f_first_from(i_en_mask, r_cur);
  assign w_man_data   = w_sel_ok ? f_word(i_data_in, i_sel) : '0;

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_dwell <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_dwell <= w_dwell_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next-state and next-output logic. The registered outputs always show the
  // channel that cur holds after the edge, so a channel is visible for
  // exactly DWELL cycles and a skip shows up one cycle after the mask change.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_dwell_nxt = r_dwell;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;

    case (r_state)
      ST_IDLE, ST_MANUAL: begin
        w_dwell_nxt = '0;
        if (i_mode) begin
          // Scan entry: start from sel (out-of-range sel searches from 0).
          w_state_nxt = ST_SCAN;
          if (w_any_en) begin
            w_cur_nxt   = w_entry_ch;
            w_data_nxt  = f_word(i_data_in, w_entry_ch);
            w_ch_nxt    = w_entry_ch;
            w_valid_nxt = 1'b1;
          end else begin
            w_cur_nxt   = w_sel_norm;
            w_data_nxt  = '0;
            w_ch_nxt    = w_sel_norm;
            w_valid_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = ST_MANUAL;
          w_data_nxt  = w_man_data;
          w_ch_nxt    = i_sel;
          w_valid_nxt = w_sel_ok;
        end
      end

      ST_SCAN: begin
        if (!i_mode) begin
          // Mode change beats any pending advance or skip.
          w_state_nxt = ST_MANUAL;
          w_dwell_nxt = '0;
          w_data_nxt  = w_man_data;
          w_ch_nxt    = i_sel;
          w_valid_nxt = w_sel_ok;
        end else if (!w_any_en) begin
          w_data_nxt  = '0;
          w_valid_nxt = 1'b0;
        end else if (!r_valid) begin
          // Mask just came back from empty: search includes cur itself.
          w_cur_nxt   = w_recover_ch;
          w_dwell_nxt = '0;
          w_data_nxt  = f_word(i_data_in, w_recover_ch);
          w_ch_nxt    = w_recover_ch;
          w_valid_nxt = 1'b1;
        end else if (!i_en_mask[r_cur] || ((r_dwell == DWELL_LAST) && !i_hold)) begin
          // Normal advance or forced skip of a disabled channel (hold ignored).
          w_cur_nxt   = w_next_ch;
          w_dwell_nxt = '0;
          w_data_nxt  = f_word(i_data_in, w_next_ch);
          w_ch_nxt    = w_next_ch;
          w_valid_nxt = 1'b1;
          w_wrap_nxt  = (w_next_ch <= r_cur);
        end else begin
          if (i_hold) begin
            w_dwell_nxt = r_dwell;
          end else begin
            w_dwell_nxt = r_dwell + DW_W'(1);
          end
          w_data_nxt  = f_word(i_data_in, r_cur);
          w_ch_nxt    = r_cur;
          w_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cur_nxt   = '0;
        w_dwell_nxt = '0;
        w_data_nxt  = '0;
        w_ch_nxt    = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_data_out = r_data;
  assign o_ch_out   = r_ch;
  assign o_valid    = r_valid;
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_scan_mux_nto1.sv
// ---------------------------------------------------------------------------
// tb_scan_mux_nto1
//   Directed bench for scan_mux_nto1 (WIDTH=8, CHANNELS=8, DWELL=4) plus a
//   CHANNELS=6 instance for the out-of-range manual select. Channel k carries
//   8'h10+k unless a vector overrides one channel.
// ---------------------------------------------------------------------------
module tb_scan_mux_nto1;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [7:0] mask;
    logic       hold;
    logic [2:0] ov_ch;
    logic [7:0] ov_val;
    logic [7:0] e_data;
    logic [2:0] e_ch;
    logic       e_valid;
    logic       e_wrap;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [63:0] data_in;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  en_mask;
  logic        hold;
  logic [7:0]  data_out;
  logic [2:0]  ch_out;
  logic        valid;
  logic        wrap;

  logic [47:0] data6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [5:0]  mask6;
  logic        hold6;
  logic [7:0]  data_out6;
  logic [2:0]  ch_out6;
  logic        valid6;
  logic        wrap6;

  int checks   = 0;
  int failures = 0;

  scan_mux_nto1 #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_mode(mode), .i_sel(sel),
    .i_en_mask(en_mask), .i_hold(hold), .o_data_out(data_out), .o_ch_out(ch_out),
    .o_valid(valid), .o_wrap(wrap)
  );

  scan_mux_nto1 #(.WIDTH(8), .CHANNELS(6), .DWELL(4)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_data_in(data6), .i_mode(mode6), .i_sel(sel6),
    .i_en_mask(mask6), .i_hold(hold6), .o_data_out(data_out6), .o_ch_out(ch_out6),
    .o_valid(valid6), .o_wrap(wrap6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input logic [2:0] ovc, input logic [7:0] ovv);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*8 +: 8] = 8'h10 + 8'(k);
    end
    d[ovc*8 +: 8] = ovv;
    return d;
  endfunction

  function automatic vec_t V(input logic m, input logic [2:0] s, input logic [7:0] msk,
                             input logic h, input logic [2:0] oc, input logic [7:0] ov,
                             input logic [7:0] ed, input logic [2:0] ec, input logic ev,
                             input logic ew);
    vec_t v;
    v.mode = m; v.sel = s; v.mask = msk; v.hold = h; v.ov_ch = oc; v.ov_val = ov;
    v.e_data = ed; v.e_ch = ec; v.e_valid = ev; v.e_wrap = ew;
    return v;
  endfunction

  // Apply one vector, clock once, compare #1 after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    mode    = v.mode;
    sel     = v.sel;
    en_mask = v.mask;
    hold    = v.hold;
    data_in = mk_data(v.ov_ch, v.ov_val);
    @(posedge clk);
    #1;
    chk({tag, ".data"},  32'(data_out), 32'(v.e_data));
    chk({tag, ".valid"}, 32'(valid),    32'(v.e_valid));
    chk({tag, ".wrap"},  32'(wrap),     32'(v.e_wrap));
    if (v.e_valid) begin
      chk({tag, ".ch"}, 32'(ch_out), 32'(v.e_ch));
    end
  endtask

  vec_t  ta[4];
  vec_t  tc[$];
  int    wrap_cnt;
  int    exp_ch;
  logic [2:0] seq [3];

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 3'd3; en_mask = 8'hFF; hold = 1'b0;
    data_in = mk_data(3'd3, 8'h13);
    mode6 = 1'b0; sel6 = 3'd7; mask6 = 6'h3F; hold6 = 1'b0;
    data6 = mk_data(3'd3, 8'h13)[47:0];

    // Reset state.
    #1;
    chk("rst.data",  32'(data_out), 32'h0);
    chk("rst.ch",    32'(ch_out),   32'h0);
    chk("rst.valid", 32'(valid),    32'h0);
    chk("rst.wrap",  32'(wrap),     32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("idle.valid", 32'(valid), 32'h0);

    // Manual select, live data tracking, hold ignored in manual mode.
    ta[0] = V(1'b0, 3'd3, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h13, 3'd3, 1'b1, 1'b0);
    ta[1] = V(1'b0, 3'd3, 8'hFF, 1'b0, 3'd3, 8'hA5, 8'hA5, 3'd3, 1'b1, 1'b0);
    ta[2] = V(1'b0, 3'd6, 8'hFF, 1'b1, 3'd3, 8'hA5, 8'h16, 3'd6, 1'b1, 1'b0);
    ta[3] = V(1'b0, 3'd0, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h10, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_vec(ta[i], $sformatf("man%0d", i));
    end

    // CHANNELS=6 instance: sel=7 is out of range, then sel=5 is legal.
    chk("c6.oor.valid", 32'(valid6),    32'h0);
    chk("c6.oor.data",  32'(data_out6), 32'h0);
    chk("c6.oor.ch",    32'(ch_out6),   32'h7);
    sel6 = 3'd5;
    @(posedge clk); #1;
    chk("c6.sel5.valid", 32'(valid6),    32'h1);
    chk("c6.sel5.data",  32'(data_out6), 32'h15);
    chk("c6.sel5.ch",    32'(ch_out6),   32'h5);

    // Full-mask rotation: 0..7 then 0, four cycles each, one wrap.
    mode = 1'b1; sel = 3'd0; en_mask = 8'hFF; hold = 1'b0;
    data_in = mk_data(3'd3, 8'h13);
    wrap_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      @(posedge clk); #1;
      exp_ch = (i / 4) % 8;
      chk($sformatf("rot%0d.ch", i),   32'(ch_out),   32'(exp_ch));
      chk($sformatf("rot%0d.data", i), 32'(data_out), 32'(8'h10 + 8'(exp_ch)));
      chk($sformatf("rot%0d.wrap", i), 32'(wrap),     32'(i == 32));
      if (wrap) wrap_cnt++;
    end
    chk("rot.wrap_count", 32'(wrap_cnt), 32'd1);

    // Sparse mask 1001_0100: cur 0 disabled -> 2, then 4, 7, 2 (wrap), 4.
    seq[0] = 3'd2; seq[1] = 3'd4; seq[2] = 3'd7;
    en_mask = 8'b1001_0100;
    for (int j = 0; j < 17; j++) begin
      @(posedge clk); #1;
      chk($sformatf("sp%0d.ch", j),   32'(ch_out), 32'(seq[(j / 4) % 3]));
      chk($sformatf("sp%0d.wrap", j), 32'(wrap),   32'(j == 12));
    end

    // Corner sequence: skip on disable, hold, empty mask, single channel,
    // mode-switch collision, rescan from sel.
    tc.push_back(V(1'b1, 3'd0, 8'h84, 1'b0, 3'd3, 8'h13, 8'h17, 3'd7, 1'b1, 1'b0));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) tc.push_back(V(1'b1, 3'd0, 8'h84, 1'b1, 3'd7, 8'h5A, 8'h5A, 3'd7, 1'b1, 1'b0));
      else        tc.push_back(V(1'b1, 3'd0, 8'h84, 1'b1, 3'd3, 8'h13, 8'h17, 3'd7, 1'b1, 1'b0));
    end
    for (int i = 0; i < 3; i++)
      tc.push_back(V(1'b1, 3'd0, 8'h84, 1'b0, 3'd3, 8'h13, 8'h17, 3'd7, 1'b1, 1'b0));
    tc.push_back(V(1'b1, 3'd0, 8'h84, 1'b0, 3'd3, 8'h13, 8'h12, 3'd2, 1'b1, 1'b1));
    tc.push_back(V(1'b1, 3'd0, 8'h00, 1'b0, 3'd3, 8'h13, 8'h00, 3'd0, 1'b0, 1'b0));
    tc.push_back(V(1'b1, 3'd0, 8'h00, 1'b0, 3'd3, 8'h13, 8'h00, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 9; i++)
      tc.push_back(V(1'b1, 3'd0, 8'h20, 1'b0, 3'd3, 8'h13, 8'h15, 3'd5, 1'b1, (i == 4) || (i == 8)));
    for (int i = 0; i < 3; i++)
      tc.push_back(V(1'b1, 3'd0, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h15, 3'd5, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      tc.push_back(V(1'b1, 3'd0, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h16, 3'd6, 1'b1, 1'b0));
    tc.push_back(V(1'b0, 3'd1, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h11, 3'd1, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      tc.push_back(V(1'b1, 3'd1, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h11, 3'd1, 1'b1, 1'b0));
    tc.push_back(V(1'b1, 3'd1, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h12, 3'd2, 1'b1, 1'b0));
    tc.push_back(V(1'b0, 3'd5, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h15, 3'd5, 1'b1, 1'b0));
    tc.push_back(V(1'b1, 3'd5, 8'hFF, 1'b0, 3'd3, 8'h13, 8'h15, 3'd5, 1'b1, 1'b0));
    foreach (tc[i]) begin
      run_vec(tc[i], $sformatf("cor%0d", i));
    end

    // Async reset mid-scan on ch 5: outputs clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst.data",  32'(data_out), 32'h0);
    chk("arst.ch",    32'(ch_out),   32'h0);
    chk("arst.valid", 32'(valid),    32'h0);
    chk("arst.wrap",  32'(wrap),     32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("arst.idle.valid", 32'(valid), 32'h0);
    @(posedge clk); #1;
    chk("arst.after.valid", 32'(valid),    32'h1);
    chk("arst.after.ch",    32'(ch_out),   32'h5);
    chk("arst.after.data",  32'(data_out), 32'h15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
